// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: opcodes, FSM states and
// datapath mux/ALU codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluXor   = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StLwWb,
    StMemWr,
    StRExec,
    StRWb,
    StBranch,
    StXoriExec,
    StXoriWb,
    StJump,
    StTrap
  } state_e;

  // States that hold mem_req and therefore run the timeout counter.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory-wait timeout counter: counts unanswered request cycles and flags the cycle on which
// the Limit-th consecutive unanswered cycle occurs.
module mc_mem_timer #(
  parameter int unsigned Width = 4,
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the unanswered cycles seen so far, so this fires on the Limit-th one.
  assign timeout_o = en_i && (cnt_q == Width'(Limit - 1));

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control unit with memory handshake, timeout trap and retire strobe.
// Optional performance counters are compiled in when MC_PERF_CNT_EN is defined.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned AluOpW     = 2,
  parameter int unsigned TmoW       = 4,
  parameter int unsigned MemTimeout = 15
`ifdef MC_PERF_CNT_EN
  ,
  parameter int unsigned CntW       = 32
`endif
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              run_i,
  input  logic [5:0]        opcode_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              iord_o,
  output logic              ir_write_o,
  output logic              pc_write_o,
  output logic              pc_write_cond_o,
  output logic [1:0]        pc_source_o,
  output logic              alu_src_a_o,
  output logic [1:0]        alu_src_b_o,
  output logic [AluOpW-1:0] alu_op_o,
  output logic              sign_zero_o,
  output logic              reg_dst_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              instr_done_o,
  output logic              illegal_op_o,
  output logic              bus_err_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CntW-1:0]   cycle_cnt_o,
  output logic [CntW-1:0]   retired_cnt_o
`endif
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       in_mem;
  logic       timeout;
  logic [1:0] alu_op;

  assign in_mem = is_mem_state(state_q);

  mc_mem_timer #(
    .Width(TmoW),
    .Limit(MemTimeout)
  ) u_mem_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (!in_mem || mem_ready_i),
    .en_i     (in_mem && !mem_ready_i),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ready_i) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        case (opcode_i)
          OpRtype:    state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBne:      state_d = StBranch;
          OpXori:     state_d = StXoriExec;
          OpJ:        state_d = StJump;
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr:  state_d = (opcode_i == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready_i) begin
          state_d = StLwWb;
        end else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StMemWr: begin
        if (mem_ready_i) begin
          state_d = run_i ? StFetch : StIdle;
        end else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StRExec:    state_d = StRWb;
      StXoriExec: state_d = StXoriWb;
      StLwWb, StRWb, StBranch, StXoriWb, StJump: begin
        state_d = run_i ? StFetch : StIdle;
      end
      StTrap:     state_d = StTrap;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Moore decode; only FETCH's IR/PC load and MEM_WR's retire look at mem_ready.
  always_comb begin
    mem_req_o       = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = PcSrcAlu;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SrcBRt;
    alu_op          = AluAdd;
    sign_zero_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    instr_done_o    = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req_o   = 1'b1;
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: alu_src_b_o = SrcBImmSh;
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: begin
        mem_req_o  = 1'b1;
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      StLwWb: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StMemWr: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StRExec: begin
        alu_src_a_o = 1'b1;
        alu_op      = AluFunct;
      end
      StRWb: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        alu_op          = AluSub;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PcSrcAluOut;
        instr_done_o    = 1'b1;
      end
      StXoriExec: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_op      = AluXor;
        sign_zero_o = 1'b1;
      end
      StXoriWb: begin
        reg_write_o  = 1'b1;
        sign_zero_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StJump: begin
        pc_write_o   = 1'b1;
        pc_source_o  = PcSrcJump;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op_o     = AluOpW'(alu_op);
  assign illegal_op_o = illegal_q;
  assign bus_err_o    = bus_err_q;

`ifdef MC_PERF_CNT_EN
  logic [CntW-1:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != StIdle && state_q != StTrap) cycle_cnt_q <= cycle_cnt_q + CntW'(1);
      if (instr_done_o) retired_cnt_q <= retired_cnt_q + CntW'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`endif

endmodule
